// File: rtl/alu_ctrl_pkg.sv
// Shared opcode/state encodings and instruction field positions for the
// ALU controller and the ALU datapath.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_INV  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_LOAD = 3'd6,
    OP_MOV  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int INSTR_W = 10;
  localparam int OPC_MSB = 9;
  localparam int OPC_LSB = 7;
  localparam int RX_MSB  = 6;
  localparam int RX_LSB  = 5;
  localparam int RY_MSB  = 4;
  localparam int RY_LSB  = 3;

  function automatic logic is_alu_op(input logic [2:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec2to4.sv
// 2-to-4 one-hot decoder with enable; produces the register-file write strobes.
module alu_ctrl_dec2to4 (
  input  logic [1:0] sel,
  input  logic       en,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = 4'b0000;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/alu_controller.sv
// Multi-cycle ALU sequencer: LOAD/MOV in one step, ALU ops in three.
// Optional CurState debug port under `ALU_CONTROLLER_STATE_OUT_EN.
//
// state  | meaning
// IDLE   | waiting for Run, captures Instr into IR
// T1     | LOAD/MOV write Rx; ALU ops load A from Rx
// T2     | ALU op on A and Ry, result into G
// T3     | G written back to Rx
// DONE   | one-cycle completion pulse
module alu_controller
  import alu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Run,
  input  logic [9:0]  Instr,
  output logic [2:0]  ALUControl,
  output logic [3:0]  Rin,
  output logic [1:0]  RoutSel,
  output logic        RoutEn,
  output logic        Ain,
  output logic        Gin,
  output logic        Gout,
  output logic        DINout,
  output logic        Done
`ifdef ALU_CONTROLLER_STATE_OUT_EN
  ,
  output logic [2:0]  CurState
`endif
);

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;

  logic [2:0] opcode;
  logic [1:0] rx, ry;
  logic       rin_en;
  logic       unused_ir_bits;

  assign opcode         = ir_q[OPC_MSB:OPC_LSB];
  assign rx             = ir_q[RX_MSB:RX_LSB];
  assign ry             = ir_q[RY_MSB:RY_LSB];
  assign unused_ir_bits = ^ir_q[2:0];

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (Run) begin
          ir_d    = Instr;
          state_d = S_T1;
        end
      end
      S_T1:    state_d = is_alu_op(opcode) ? S_T2 : S_DONE;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    RoutSel    = 2'b00;
    RoutEn     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    DINout     = 1'b0;
    Done       = 1'b0;
    rin_en     = 1'b0;
    case (state_q)
      S_T1: begin
        if (opcode == OP_LOAD) begin
          DINout = 1'b1;
          rin_en = 1'b1;
        end else if (opcode == OP_MOV) begin
          RoutEn  = 1'b1;
          RoutSel = ry;
          rin_en  = 1'b1;
        end else begin
          RoutEn  = 1'b1;
          RoutSel = rx;
          Ain     = 1'b1;
        end
      end
      S_T2: begin
        RoutEn     = 1'b1;
        RoutSel    = ry;
        Gin        = 1'b1;
        ALUControl = opcode;
      end
      S_T3: begin
        Gout   = 1'b1;
        rin_en = 1'b1;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  alu_ctrl_dec2to4 u_rin_dec (
    .sel    (rx),
    .en     (rin_en),
    .onehot (Rin)
  );

`ifdef ALU_CONTROLLER_STATE_OUT_EN
  assign CurState = state_q;
`endif

endmodule

// File: tb/tb_alu_controller.sv
// Cycle-accurate scoreboard bench for alu_controller: every cycle's output
// vector is compared with the sequence predicted when the instruction was issued.
module tb_alu_controller;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Run;
  logic [9:0] Instr;
  logic [2:0] ALUControl;
  logic [3:0] Rin;
  logic [1:0] RoutSel;
  logic       RoutEn, Ain, Gin, Gout, DINout, Done;
`ifdef ALU_CONTROLLER_STATE_OUT_EN
  logic [2:0] CurState;
`endif

  alu_controller dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Run        (Run),
    .Instr      (Instr),
    .ALUControl (ALUControl),
    .Rin        (Rin),
    .RoutSel    (RoutSel),
    .RoutEn     (RoutEn),
    .Ain        (Ain),
    .Gin        (Gin),
    .Gout       (Gout),
    .DINout     (DINout),
    .Done       (Done)
`ifdef ALU_CONTROLLER_STATE_OUT_EN
    ,
    .CurState   (CurState)
`endif
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];
  logic        cur_idle;

  // Vector layout: {ALUControl, Rin, RoutSel, RoutEn, Ain, Gin, Gout, DINout, Done}
  function automatic logic [14:0] mk(input logic [2:0] ctrl, input logic [3:0] rin,
                                     input logic [1:0] rsel, input logic routen,
                                     input logic ain, input logic gin, input logic gout,
                                     input logic din, input logic done);
    return {ctrl, rin, rsel, routen, ain, gin, gout, din, done};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] r);
    logic [3:0] v;
    v = 4'b0000;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic push_model(input logic [9:0] ins);
    logic [2:0] op;
    logic [1:0] rx, ry;
    op = ins[9:7];
    rx = ins[6:5];
    ry = ins[4:3];
    if (op == 3'b110) begin
      exp_q.push_back(mk(3'b000, onehot(rx), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end else if (op == 3'b111) begin
      exp_q.push_back(mk(3'b000, onehot(rx), ry, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end else begin
      exp_q.push_back(mk(3'b000, 4'b0000, rx, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(op, 4'b0000, ry, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(3'b000, onehot(rx), 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    exp_q.push_back(mk(3'b000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  // One clock: predict from the inputs about to be sampled, then compare.
  task automatic step(input string tag);
    logic [14:0] exp_v, obs_v;
    if (!Resetn) exp_q.delete();
    else if (Run && cur_idle) push_model(Instr);
    @(posedge Clock);
    #2;
    if (exp_q.size() > 0) begin
      exp_v    = exp_q.pop_front();
      cur_idle = 1'b0;
    end else begin
      exp_v    = '0;
      cur_idle = 1'b1;
    end
    obs_v = {ALUControl, Rin, RoutSel, RoutEn, Ain, Gin, Gout, DINout, Done};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed ctrl/rin/rsel/en/ain/gin/gout/din/done=%h required=%h",
             tag, obs_v, exp_v);
    end
    checks++;
    assert (({2'b00, RoutEn} + {2'b00, Gout} + {2'b00, DINout}) <= 3'd1) else begin
      errors++;
      $error("FAIL %s bus_excl: observed RoutEn=%b Gout=%b DINout=%b required at most one",
             tag, RoutEn, Gout, DINout);
    end
  endtask

  task automatic issue(input string tag, input logic [9:0] ins, input int drain);
    Run   = 1'b1;
    Instr = ins;
    step({tag, "_start"});
    Run   = 1'b0;
    Instr = 10'h3ff;
    for (int i = 0; i < drain; i++) step(tag);
  endtask

  initial begin
    cur_idle = 1'b1;
    Resetn   = 1'b0;
    Run      = 1'b0;
    Instr    = '0;
    step("reset0");
    step("reset1");
`ifdef ALU_CONTROLLER_STATE_OUT_EN
    checks++;
    assert (CurState === 3'd0) else begin
      errors++;
      $error("FAIL cur_state_reset: observed %0d required 0", CurState);
    end
`endif
    Resetn = 1'b1;
    step("idle");

    issue("load_r2",   10'b110_10_00_000, 3);
    issue("sub_r1_r2", 10'b001_01_10_000, 5);
    issue("mov_r3_r0", 10'b111_11_00_000, 3);
    issue("sub_r1_r1", 10'b001_01_01_000, 5);
    issue("add_r0_r3", 10'b000_00_11_101, 5);
    issue("inv_r2_r1", 10'b010_10_01_000, 5);
    issue("and_r3_r2", 10'b011_11_10_000, 5);
    issue("or_r1_r0",  10'b100_01_00_000, 5);

    // Reset lands while an XOR is in T2: nothing of T3/DONE may follow.
    Run   = 1'b1;
    Instr = 10'b101_10_11_000;
    step("xor_t1");
    Run = 1'b0;
    step("xor_t2");
    Resetn = 1'b0;
    step("xor_reset");
    Resetn = 1'b1;
    for (int i = 0; i < 4; i++) step("xor_after_reset");

    // Reset wins over a simultaneous Run.
    Resetn = 1'b0;
    Run    = 1'b1;
    Instr  = 10'b110_01_00_000;
    step("reset_vs_run");
    Resetn = 1'b1;
    Run    = 1'b0;
    for (int i = 0; i < 2; i++) step("post_reset_idle");

    // Run held high, Instr changing each cycle: back-to-back execution.
    Run = 1'b1;
    for (int i = 0; i < 24; i++) begin
      Instr = 10'($urandom);
      step("run_held");
    end
    Run = 1'b0;
    for (int i = 0; i < 6; i++) step("run_held_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
